// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small transmit FIFO and build-time frame format.
// Frames: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_cfg #(
   parameter int BAUD       = 104,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 wr,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 full,
   output logic                 empty,
   output logic                 busy
);

   // state | meaning
   // IDLE  | line high, waiting for FIFO data
   // START | start bit (tx=0)
   // DATA  | data bits, LSB first
   // PAR   | parity bit (only when PARITY != 0)
   // STOP  | stop bit(s), tx=1
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   localparam int BW = (BAUD < 2) ? 1 : $clog2(BAUD);
   localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [BW-1:0] BAUD_LD = BW'(BAUD - 1);

   if (BAUD < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
      $error("uart_tx_cfg: illegal parameter value");
   end

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 push, pop;
   logic [DATA_BITS-1:0] head;

   state_t               state_q, state_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [2:0]           bit_q, bit_d;
   logic                 tx_q, tx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 bit_end, start;

   assign full  = (cnt_q == CW'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);
   assign push  = wr & ~full;
   assign head  = mem_q[rptr_q];

   always_comb begin
      wptr_d = wptr_q + AW'(push);
      rptr_d = rptr_q + AW'(pop);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
   end

   // Storage is never observed before being written, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= data;
      shift_q <= shift_d;
      par_q   <= par_d;
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      start   = 1'b0;
      bit_end = (baud_q == '0);
      baud_d  = bit_end ? BAUD_LD : baud_q - 1'b1;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!empty) start = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = 3'(DATA_BITS - 1);
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == '0) begin
                  if (PARITY != 0) begin
                     state_d = PAR;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     bit_d   = 3'(STOP_BITS - 1);
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q - 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_d = STOP;
               bit_d   = 3'(STOP_BITS - 1);
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_q == '0) begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  if (!empty) start = 1'b1;
               end else begin
                  bit_d = bit_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
         end
      endcase

      // Shared by IDLE and the last STOP cycle so back-to-back frames have no gap.
      if (start) begin
         pop     = 1'b1;
         shift_d = head;
         par_d   = (^head) ^ (PARITY == 2);
         state_d = START;
         baud_d  = BAUD_LD;
         tx_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four frame formats at BAUD=4, FIFO fill,
// mid-frame reset and a write on the last stop cycle.
module tb_uart_tx_cfg;

   logic       clk;
   logic       rstn;
   logic [3:0] wr_v;
   logic [7:0] data_v [3];
   logic [4:0] data5;
   logic [3:0] tx_v, full_v, empty_v, busy_v;

   int checks = 0;
   int errors = 0;

   uart_tx_cfg #(.BAUD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rstn(rstn), .wr(wr_v[0]), .data(data_v[0]),
      .tx(tx_v[0]), .full(full_v[0]), .empty(empty_v[0]), .busy(busy_v[0]));
   uart_tx_cfg #(.BAUD(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rstn(rstn), .wr(wr_v[1]), .data(data_v[1]),
      .tx(tx_v[1]), .full(full_v[1]), .empty(empty_v[1]), .busy(busy_v[1]));
   uart_tx_cfg #(.BAUD(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rstn(rstn), .wr(wr_v[2]), .data(data_v[2]),
      .tx(tx_v[2]), .full(full_v[2]), .empty(empty_v[2]), .busy(busy_v[2]));
   uart_tx_cfg #(.BAUD(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
      .clk(clk), .rstn(rstn), .wr(wr_v[3]), .data(data5),
      .tx(tx_v[3]), .full(full_v[3]), .empty(empty_v[3]), .busy(busy_v[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      int         sel;
      logic [7:0] din;
      logic [0:11] bits;
      int         nbits;
      int         flen;
   } vec_t;

   vec_t tbl [8];

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int sel, input logic [7:0] v, input logic w);
      if (sel == 3) data5 = v[4:0];
      else data_v[sel] = v;
      wr_v[sel] = w;
   endtask

   // Entered one sample after the edge that put the start bit on tx.
   task automatic check_bits(input int sel, input logic [0:11] bits, input int nbits,
                             input int flen);
      int bc = 0;
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < 4; c++) begin
            chk_b($sformatf("bit%0d_c%0d_u%0d", i, c, sel), tx_v[sel], bits[i]);
            if (busy_v[sel]) bc++;
            step;
         end
      end
      chk_b("busy_after_frame", busy_v[sel], 1'b0);
      chk_b("tx_after_frame", tx_v[sel], 1'b1);
      chk_i("frame_len", bc, flen);
   endtask

   function automatic logic exp_fifo(input int t);
      int f = t / 40;
      int b = (t % 40) / 4;
      logic [7:0] v = 8'hA1 + 8'(f);
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return v[b-1];
   endfunction

   initial begin
      logic stayed;
      int   bc;

      tbl[0] = '{0, 8'h55, 12'b010101010100, 10, 40};
      tbl[1] = '{0, 8'hA3, 12'b011000101100, 10, 40};
      tbl[2] = '{1, 8'h07, 12'b011100000110, 11, 44};
      tbl[3] = '{2, 8'h07, 12'b011100000010, 11, 44};
      tbl[4] = '{1, 8'h00, 12'b000000000010, 11, 44};
      tbl[5] = '{2, 8'h00, 12'b000000000110, 11, 44};
      tbl[6] = '{3, 8'h13, 12'b011001110000, 8, 32};
      tbl[7] = '{3, 8'h0A, 12'b001010110000, 8, 32};

      rstn   = 1'b1;
      wr_v   = '0;
      data5  = '0;
      for (int i = 0; i < 3; i++) data_v[i] = '0;
      #1 rstn = 1'b0;
      #2;
      for (int i = 0; i < 4; i++) begin
         chk_b($sformatf("rst_tx_u%0d", i), tx_v[i], 1'b1);
         chk_b($sformatf("rst_busy_u%0d", i), busy_v[i], 1'b0);
         chk_b($sformatf("rst_empty_u%0d", i), empty_v[i], 1'b1);
         chk_b($sformatf("rst_full_u%0d", i), full_v[i], 1'b0);
      end
      #20 rstn = 1'b1;
      step;
      step;

      for (int v = 0; v < 8; v++) begin
         drive(tbl[v].sel, tbl[v].din, 1'b1);
         step;
         drive(tbl[v].sel, 8'h00, 1'b0);
         chk_b($sformatf("v%0d_empty_fall", v), empty_v[tbl[v].sel], 1'b0);
         chk_b($sformatf("v%0d_tx_idle", v), tx_v[tbl[v].sel], 1'b1);
         chk_b($sformatf("v%0d_busy_idle", v), busy_v[tbl[v].sel], 1'b0);
         step;
         chk_b($sformatf("v%0d_start_lat", v), tx_v[tbl[v].sel], 1'b0);
         check_bits(tbl[v].sel, tbl[v].bits, tbl[v].nbits, tbl[v].flen);
         chk_b($sformatf("v%0d_empty_end", v), empty_v[tbl[v].sel], 1'b1);
         step;
      end

      // FIFO fill: first byte pops at once, four queue, the sixth is dropped.
      bc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 8'hA1 + 8'(i), 1'b1);
         step;
         chk_b($sformatf("fill_full_%0d", i), full_v[0], (i >= 4));
         chk_b($sformatf("fill_empty_%0d", i), empty_v[0], 1'b0);
         if (i >= 1) begin
            chk_b($sformatf("fill_tx_t%0d", i - 1), tx_v[0], exp_fifo(i - 1));
            if (busy_v[0]) bc++;
         end
      end
      drive(0, 8'h00, 1'b0);
      for (int t = 5; t < 200; t++) begin
         step;
         chk_b($sformatf("stream_tx_t%0d", t), tx_v[0], exp_fifo(t));
         if (busy_v[0]) bc++;
         if (t == 39) chk_b("full_before_pop", full_v[0], 1'b1);
         if (t == 40) chk_b("full_after_pop", full_v[0], 1'b0);
         if (t == 159) chk_b("empty_before_last", empty_v[0], 1'b0);
         if (t == 160) chk_b("empty_after_last", empty_v[0], 1'b1);
      end
      step;
      chk_i("stream_busy_cycles", bc, 200);
      chk_b("stream_busy_end", busy_v[0], 1'b0);
      chk_b("stream_empty_end", empty_v[0], 1'b1);
      stayed = 1'b1;
      for (int t = 0; t < 50; t++) begin
         step;
         if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) stayed = 1'b0;
      end
      chk_b("dropped_byte_not_sent", stayed, 1'b1);

      // Reset during data bit 3 with two entries queued.
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h11 * 8'(i + 1), 1'b1);
         step;
      end
      drive(0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) step;
      chk_b("pre_rst_d3", tx_v[0], 1'b0);
      chk_b("pre_rst_empty", empty_v[0], 1'b0);
      chk_b("pre_rst_busy", busy_v[0], 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk_b("mid_rst_tx", tx_v[0], 1'b1);
      chk_b("mid_rst_busy", busy_v[0], 1'b0);
      chk_b("mid_rst_empty", empty_v[0], 1'b1);
      chk_b("mid_rst_full", full_v[0], 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk_b("mid_rst_tx_held", tx_v[0], 1'b1);
      #1 rstn = 1'b1;
      stayed = 1'b1;
      for (int t = 0; t < 60; t++) begin
         step;
         if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || empty_v[0] !== 1'b1) stayed = 1'b0;
      end
      chk_b("post_rst_quiet", stayed, 1'b1);

      // Write on the last stop cycle with an empty FIFO.
      drive(0, 8'h55, 1'b1);
      step;
      drive(0, 8'h00, 1'b0);
      step;
      chk_b("b2b_start", tx_v[0], 1'b0);
      for (int i = 0; i < 39; i++) step;
      chk_b("last_stop_busy", busy_v[0], 1'b1);
      chk_b("last_stop_tx", tx_v[0], 1'b1);
      drive(0, 8'h3C, 1'b1);
      step;
      drive(0, 8'h00, 1'b0);
      chk_b("gap_busy", busy_v[0], 1'b0);
      chk_b("gap_tx", tx_v[0], 1'b1);
      chk_b("gap_empty", empty_v[0], 1'b0);
      step;
      chk_b("gap_next_busy", busy_v[0], 1'b1);
      check_bits(0, 12'b000111100100, 10, 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
